// File: rtl/core_pkg.sv
// Shared core types: adder ops, divider ops and divider FSM states.
package core_pkg;

  localparam int XLEN      = 32;
  localparam int DIV_ITERS = XLEN;

  typedef enum logic [1:0] {
    ADDER_ADD,
    ADDER_SUB,
    ADDER_LTU
  } adderOp_t;

  typedef enum logic [1:0] {
    DIV_S,
    DIV_U,
    REM_S,
    REM_U
  } divOp_t;

  typedef enum logic [2:0] {
    IDLE,
    NEG_A,
    NEG_B,
    ITER,
    FIX,
    DONE
  } divState_t;

  function automatic logic div_signed(divOp_t op);
    return (op == DIV_S) || (op == REM_S);
  endfunction

  function automatic logic div_rem(divOp_t op);
    return (op == REM_S) || (op == REM_U);
  endfunction

endpackage

// File: rtl/div_seq.sv
// Iterative RV32M divider driving the core's shared adder.
// DIV_ZERO_FAST_EN: divide-by-zero skips straight to DONE.
module div_seq
  import core_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  divOp_t           in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output adderOp_t         add_op,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_cout
);

  localparam int CW = $clog2(WIDTH);

  divState_t        state_q, state_d;
  divOp_t           op_q, op_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             na_q, na_d;
  logic             nb_q, nb_d;

  logic [WIDTH:0]   trial;
  logic             qbit;
  logic [WIDTH-1:0] res;
  logic             neg;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = out_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    q_d     = q_q;
    r_d     = r_q;
    b_d     = b_q;
    out_d   = out_q;
    cnt_d   = cnt_q;
    na_d    = na_q;
    nb_d    = nb_q;
    add_op  = ADDER_ADD;
    add_a   = '0;
    add_b   = '0;
    trial   = {r_q, q_q[WIDTH-1]};
    qbit    = 1'b0;
    res     = div_rem(op_q) ? r_q : q_q;
    neg     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          q_d     = in_a;
          b_d     = in_b;
          r_d     = '0;
          na_d    = div_signed(in_op) & in_a[WIDTH-1];
          nb_d    = div_signed(in_op) & in_b[WIDTH-1];
          state_d = NEG_A;
`ifdef DIV_ZERO_FAST_EN
          if (in_b == '0) begin
            out_d   = div_rem(in_op) ? in_a : '1;
            state_d = DONE;
          end
`endif
        end
      end
      NEG_A: begin
        if (na_q) begin
          add_op = ADDER_SUB;
          add_b  = q_q;
          q_d    = add_out;
        end
        state_d = NEG_B;
      end
      NEG_B: begin
        if (nb_q) begin
          add_op = ADDER_SUB;
          add_b  = b_q;
          b_d    = add_out;
        end
        cnt_d   = CW'(DIV_ITERS - 1);
        state_d = ITER;
      end
      ITER: begin
        add_op = ADDER_SUB;
        add_a  = trial[WIDTH-1:0];
        add_b  = b_q;
        // Top bit set means r' already exceeds any WIDTH-bit divisor.
        if (trial[WIDTH] || !add_cout) begin
          r_d  = add_out;
          qbit = 1'b1;
        end else begin
          r_d  = trial[WIDTH-1:0];
          qbit = 1'b0;
        end
        q_d = {q_q[WIDTH-2:0], qbit};
        if (cnt_q == '0) begin
          state_d = FIX;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIX: begin
        neg = div_rem(op_q) ? na_q
                            : ((na_q ^ nb_q) & (b_q != '0));
        if (neg) begin
          add_op = ADDER_SUB;
          add_b  = res;
          out_d  = add_out;
        end else begin
          out_d  = res;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= DIV_S;
      q_q     <= '0;
      r_q     <= '0;
      b_q     <= '0;
      out_q   <= '0;
      cnt_q   <= '0;
      na_q    <= 1'b0;
      nb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      q_q     <= q_d;
      r_q     <= r_d;
      b_q     <= b_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      na_q    <= na_d;
      nb_q    <= nb_d;
    end
  end

endmodule
